// File: rtl/counter_reload_down.sv
// Loadable down-counter with periodic reload or one-shot stop, start/stop control and a busy flag.
// Define COUNTER_RELOAD_DOWN_ONESHOT_EN to honour the `one` input; otherwise the block is always periodic.
module counter_reload_down #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] max,
  input  logic             str,
  input  logic             stp,
  input  logic             one,
  output logic [WIDTH-1:0] cnt,
  output logic             pls,
  output logic             bsy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state;
  logic   at_zero;

  assign at_zero = (cnt == '0);
  // Terminal pulse comes from registered state only, so it does not wait on ena.
  assign pls     = bsy && at_zero;

`ifndef COUNTER_RELOAD_DOWN_ONESHOT_EN
  logic one_unused;
  assign one_unused = one;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bsy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A stop in the same cycle as a start keeps the counter idle.
          if (str && !stp) begin
            state <= RUN;
            bsy   <= 1'b1;
            cnt   <= max;
          end
        end
        RUN: begin
          if (stp) begin
            state <= IDLE;
            bsy   <= 1'b0;
            cnt   <= '0;
          end else if (str) begin
            cnt <= max;
          end else if (ena) begin
            if (!at_zero) begin
              cnt <= cnt - 1'b1;
            end else begin
`ifdef COUNTER_RELOAD_DOWN_ONESHOT_EN
              if (one) begin
                state <= IDLE;
                bsy   <= 1'b0;
              end else begin
                cnt <= max;
              end
`else
              cnt <= max;
`endif
            end
          end
        end
        default: begin
          state <= IDLE;
          bsy   <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_reload_down.sv
// Randomized self-checking bench for counter_reload_down against a rule-level reference model.
module tb_counter_reload_down;

`ifdef COUNTER_RELOAD_DOWN_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, ena, str, stp, one;
  logic [3:0] max;
  logic [3:0] cnt;
  logic       pls, bsy;

  int n_chk = 0;
  int n_err = 0;

  // Reference: running flag plus count as plain integers.
  bit m_run;
  int m_cnt;

  counter_reload_down #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .max(max), .str(str),
    .stp(stp), .one(one), .cnt(cnt), .pls(pls), .bsy(bsy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic void model_clock();
    if (stp) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (str) begin
      m_run = 1'b1;
      m_cnt = int'(max);
    end else if (m_run && ena) begin
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      else if (ONESHOT && one) m_run = 1'b0;
      else m_cnt = int'(max);
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".cnt"}, 32'(cnt), 32'(m_cnt));
    chk({tag, ".bsy"}, 32'(bsy), 32'(m_run));
    chk({tag, ".pls"}, 32'(pls), 32'(m_run && m_cnt == 0));
  endtask

  // One clock: inputs are already set, model follows the edge, outputs sampled 1ns later.
  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    ena = 1'b0; str = 1'b0; stp = 1'b0;
  endtask

  initial begin
    int seq [8];
    int pcount;
    int en_cycles;
    logic [3:0] mlist [3];

    rst = 1'b1; max = 4'd0; one = 1'b0;
    idle_inputs();
    m_run = 1'b0; m_cnt = 0;

    // Reset held 4 clocks with ena high, then idle with ena and no start.
    ena = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check_model("reset");
    end
    @(negedge clk); rst = 1'b0;
    repeat (5) step("idle_ena");

    // Periodic, max=3.
    max = 4'd3; str = 1'b1; ena = 1'b1;
    seq = '{3, 2, 1, 0, 3, 2, 1, 0};
    step("per_load");
    chk("per_seq0", 32'(cnt), 32'(seq[0]));
    chk("per_bsy", 32'(bsy), 32'd1);
    str = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step("per_run");
      chk("per_seq", 32'(cnt), 32'(seq[i]));
      chk("per_pls", 32'(pls), 32'(seq[i] == 0));
    end

    // Randomized ena with boundary limits.
    mlist[0] = 4'd0; mlist[1] = 4'd1; mlist[2] = 4'd15;
    for (int c = 0; c < 3; c++) begin
      idle_inputs(); stp = 1'b1;
      step("rnd_stop");
      stp = 1'b0; str = 1'b1; max = mlist[c];
      step("rnd_load");
      str = 1'b0;
      en_cycles = 0;
      while (en_cycles < 18) begin
        ena = 1'($urandom % 2);
        if (ena) en_cycles++;
        step("rnd_run");
        if (mlist[c] == 4'd0) chk("max0_pls", 32'(pls), 32'd1);
      end
    end

    // One-shot, max=2.
    idle_inputs(); stp = 1'b1;
    step("os_stop");
    stp = 1'b0; str = 1'b1; max = 4'd2; one = 1'b1; ena = 1'b1;
    step("os_load");
    pcount = int'(pls);
    str = 1'b0;
    step("os_1");
    pcount += int'(pls);
    step("os_0");
    pcount += int'(pls);
    chk("os_zero_pls", 32'(pls), 32'd1);
    step("os_end");
    pcount += int'(pls);
    chk("os_end_bsy", 32'(bsy), ONESHOT ? 32'd0 : 32'd1);
    chk("os_end_cnt", 32'(cnt), ONESHOT ? 32'd0 : 32'd2);
    chk("os_pulses", 32'(pcount), 32'd1);
    step("os_after");
    one = 1'b0;

    // Priority checks from cnt=5.
    idle_inputs(); stp = 1'b1;
    step("pr_stop");
    stp = 1'b0; str = 1'b1; max = 4'd5;
    step("pr_load");
    chk("pr_cnt5", 32'(cnt), 32'd5);
    stp = 1'b1;
    step("pr_both");
    chk("pr_both_bsy", 32'(bsy), 32'd0);
    chk("pr_both_cnt", 32'(cnt), 32'd0);
    stp = 1'b0;
    step("pr_reload5");
    max = 4'd9;
    step("pr_restart");
    chk("pr_restart9", 32'(cnt), 32'd9);
    str = 1'b0; max = 4'd7; ena = 1'b1;
    repeat (9) step("pr_down");
    chk("pr_at0", 32'(cnt), 32'd0);
    step("pr_reload");
    chk("pr_reload7", 32'(cnt), 32'd7);

    // Stop in IDLE has no effect; fully random traffic including one-shot.
    idle_inputs(); stp = 1'b1;
    step("idle_stp");
    step("idle_stp2");
    for (int i = 0; i < 250; i++) begin
      ena = 1'($urandom % 4 != 0);
      str = 1'($urandom % 12 == 0);
      stp = 1'($urandom % 20 == 0);
      one = 1'($urandom % 2);
      max = 4'($urandom);
      step("rnd_all");
    end

    // Asynchronous reset between edges at cnt=6.
    idle_inputs(); stp = 1'b1;
    step("ar_stop");
    stp = 1'b0; str = 1'b1; max = 4'd6;
    step("ar_load");
    chk("ar_cnt6", 32'(cnt), 32'd6);
    str = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_cnt", 32'(cnt), 32'd0);
    chk("ar_bsy", 32'(bsy), 32'd0);
    chk("ar_pls", 32'(pls), 32'd0);
    m_run = 1'b0; m_cnt = 0;
    @(negedge clk); rst = 1'b0;
    ena = 1'b1;
    step("ar_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
